// File: rtl/adc_pkg.sv
// adc_pkg: shared state encoding, defaults and LFSR constants for the ADC responder
package adc_pkg;
    typedef enum logic [2:0] {IDLE, CONVERT, READY, SHIFT, DONE} state_t;
    localparam int DATA_W_DEF = 12;
    localparam int CONV_CYCLES_DEF = 150;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois (right-shift) form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction
endpackage

// File: rtl/adc_shift_chan.sv
// adc_shift_chan: one channel's conversion latch (with UB coding) and MSB-first shift register
//   clk, rst_n : clock, async active-low reset
//   load       : capture value (coded per ub) into the latch
//   start      : copy latch into the shift register
//   shift      : advance the shift register by one bit
//   msb        : current serial bit
module adc_shift_chan
    import adc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              ub,
    input  logic              start,
    input  logic              shift,
    input  logic [DATA_W-1:0] value,
    output logic              msb
);
    localparam logic [DATA_W-1:0] MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};
    logic [DATA_W-1:0] lat_q, lat_d, sh_q, sh_d;
    always_comb begin
        lat_d = load ? (ub ? value ^ MSB_MASK : value) : lat_q;
        sh_d  = start ? lat_q : shift ? {sh_q[DATA_W-2:0], 1'b0} : sh_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_q <= '0;
            sh_q  <= '0;
        end else begin
            lat_q <= lat_d;
            sh_q  <= sh_d;
        end
    end
    assign msb = sh_q[DATA_W-1];
endmodule

// File: rtl/adc_responder.sv
// adc_responder: behavioural responder for a dual-channel serial ADC (convert, then shift MSB first)
//   CLOCK_50MHz, RESET_n           : clock, async active-low reset
//   ADC_CNVST/CS_N/SCLK/SEL/UB     : initiator controls, synchronized internally
//   ADC_SD, ADC_REFSEL             : accepted and ignored
//   ch0_a, ch1_a, ch0_b, ch1_b     : values reported for input sets A and B
//   ADC_OUT                        : serial data, bit 0 = channel 0, bit 1 = channel 1
//   conv_busy, abort_cnt           : converting flag, saturating aborted-read count
//   Define ADC_RESPONDER_NOISE_EN to add 2 LFSR noise bits to each latched value.
module adc_responder
    import adc_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int CONV_CYCLES = CONV_CYCLES_DEF
) (
    input  logic              CLOCK_50MHz,
    input  logic              RESET_n,
    input  logic              ADC_CNVST,
    input  logic              ADC_CS_N,
    input  logic              ADC_SCLK,
    input  logic              ADC_SEL,
    input  logic              ADC_UB,
    input  logic              ADC_SD,
    input  logic              ADC_REFSEL,
    output logic [1:0]        ADC_OUT,
    input  logic [DATA_W-1:0] ch0_a,
    input  logic [DATA_W-1:0] ch1_a,
    input  logic [DATA_W-1:0] ch0_b,
    input  logic [DATA_W-1:0] ch1_b,
    output logic              conv_busy,
    output logic [7:0]        abort_cnt
);
    localparam int CW = $clog2(CONV_CYCLES + 1);
    localparam int BW = $clog2(DATA_W + 1);
    // sync bit order: {ub, sel, sclk, cs_n, cnvst}; CS_N idles high
    localparam logic [4:0] SYNC_IDLE = 5'b00010;
    logic [4:0] s1_q, s1_d, s2_q, s2_d;
    logic [2:0] pv_q, pv_d;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [7:0] abort_q, abort_d;
    logic cnvst_rise, cs_fall, cs_rise, sclk_fall;
    logic load, start, shift, abort_inc, m0, m1;
    logic [DATA_W-1:0] val0, val1, in0, in1;
    logic unused_ok;
    assign unused_ok = ^{ADC_SD, ADC_REFSEL};
    assign cnvst_rise = s2_q[0] & ~pv_q[0];
    assign cs_fall    = ~s2_q[1] & pv_q[1];
    assign cs_rise    = s2_q[1] & ~pv_q[1];
    assign sclk_fall  = ~s2_q[2] & pv_q[2];
    assign val0 = s2_q[3] ? ch0_b : ch0_a;
    assign val1 = s2_q[3] ? ch1_b : ch1_a;
`ifdef ADC_RESPONDER_NOISE_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic [DATA_W:0] sum0, sum1;
    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
        sum0   = {1'b0, val0} + {{(DATA_W-1){1'b0}}, lfsr_q[1:0]};
        sum1   = {1'b0, val1} + {{(DATA_W-1){1'b0}}, lfsr_q[1:0]};
        in0    = sum0[DATA_W] ? '1 : sum0[DATA_W-1:0];
        in1    = sum1[DATA_W] ? '1 : sum1[DATA_W-1:0];
    end
    always_ff @(posedge CLOCK_50MHz or negedge RESET_n) begin
        if (!RESET_n) lfsr_q <= LFSR_SEED;
        else lfsr_q <= lfsr_d;
    end
`else
    assign in0 = val0;
    assign in1 = val1;
`endif
    always_comb begin
        s1_d = {ADC_UB, ADC_SEL, ADC_SCLK, ADC_CS_N, ADC_CNVST};
        s2_d = s1_q;
        pv_d = s2_q[2:0];
    end
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        load      = 1'b0;
        start     = 1'b0;
        shift     = 1'b0;
        abort_inc = 1'b0;
        // a new conversion request wins in every state except CONVERT
        if (cnvst_rise && state_q != CONVERT) begin
            state_d   = CONVERT;
            cnt_d     = '0;
            load      = 1'b1;
            abort_inc = state_q == SHIFT;
        end else begin
            case (state_q)
                CONVERT: begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(CONV_CYCLES - 1)) state_d = READY;
                end
                READY: if (cs_fall) begin
                    state_d = SHIFT;
                    start   = 1'b1;
                    bit_d   = '0;
                end
                SHIFT: if (cs_rise) begin
                    state_d   = IDLE;
                    abort_inc = 1'b1;
                end else if (sclk_fall) begin
                    shift = 1'b1;
                    bit_d = bit_q + BW'(1);
                    if (bit_q == BW'(DATA_W - 1)) state_d = DONE;
                end
                DONE: if (cs_rise) state_d = IDLE;
                default: ;
            endcase
        end
        abort_d = (abort_inc && abort_q != 8'hFF) ? abort_q + 8'd1 : abort_q;
    end
    always_ff @(posedge CLOCK_50MHz or negedge RESET_n) begin
        if (!RESET_n) begin
            s1_q    <= SYNC_IDLE;
            s2_q    <= SYNC_IDLE;
            pv_q    <= SYNC_IDLE[2:0];
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            abort_q <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            pv_q    <= pv_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            abort_q <= abort_d;
        end
    end
    adc_shift_chan #(.DATA_W(DATA_W)) u_ch0 (
        .clk(CLOCK_50MHz), .rst_n(RESET_n), .load(load), .ub(s2_q[4]),
        .start(start), .shift(shift), .value(in0), .msb(m0)
    );
    adc_shift_chan #(.DATA_W(DATA_W)) u_ch1 (
        .clk(CLOCK_50MHz), .rst_n(RESET_n), .load(load), .ub(s2_q[4]),
        .start(start), .shift(shift), .value(in1), .msb(m1)
    );
    assign ADC_OUT   = state_q == SHIFT ? {m1, m0} : 2'b00;
    assign conv_busy = state_q == CONVERT;
    assign abort_cnt = abort_q;
endmodule

// File: tb/tb_adc_responder.sv
// tb_adc_responder: directed checks of conversion, serial readout, aborts and reset
module tb_adc_responder;
    logic clk, rst_n, cnvst, cs_n, sclk, sel, ub, sd, refsel;
    logic [1:0] adc_out;
    logic [11:0] ch0_a, ch1_a, ch0_b, ch1_b;
    logic conv_busy;
    logic [7:0] abort_cnt;
    int checks, errors, busy_n;
    logic [11:0] r0, r1;

    adc_responder dut (
        .CLOCK_50MHz(clk), .RESET_n(rst_n), .ADC_CNVST(cnvst), .ADC_CS_N(cs_n),
        .ADC_SCLK(sclk), .ADC_SEL(sel), .ADC_UB(ub), .ADC_SD(sd), .ADC_REFSEL(refsel),
        .ADC_OUT(adc_out), .ch0_a(ch0_a), .ch1_a(ch1_a), .ch0_b(ch0_b), .ch1_b(ch1_b),
        .conv_busy(conv_busy), .abort_cnt(abort_cnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // pulse CNVST and count sampled cycles with conv_busy high; optional second pulse at cycle inject
    task automatic convert(input int inject, input logic [11:0] nv, output int n);
        bit seen;
        n = 0;
        seen = 1'b0;
        cnvst = 1'b1;
        for (int i = 0; i < 400; i++) begin
            step(1);
            if (i == 1) cnvst = 1'b0;
            if (i == inject) begin
                cnvst = 1'b1;
                ch0_a = nv;
            end
            if (i == inject + 2) cnvst = 1'b0;
            if (conv_busy) begin
                n++;
                seen = 1'b1;
            end else if (seen) break;
        end
    endtask

    // drop CS_N, then issue n SCLK falling edges, collecting up to 12 bits per channel
    task automatic read(input int n, output logic [11:0] v0, output logic [11:0] v1);
        cs_n = 1'b0;
        step(4);
        v0 = {11'b0, adc_out[0]};
        v1 = {11'b0, adc_out[1]};
        for (int i = 1; i <= n; i++) begin
            sclk = 1'b1;
            step(2);
            sclk = 1'b0;
            step(4);
            if (i < 12) begin
                v0 = {v0[10:0], adc_out[0]};
                v1 = {v1[10:0], adc_out[1]};
            end
        end
    endtask

    task automatic release_cs();
        cs_n = 1'b1;
        step(4);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        cnvst = 1'b0;
        cs_n = 1'b1;
        sclk = 1'b0;
        sel = 1'b0;
        ub = 1'b0;
        sd = 1'b0;
        refsel = 1'b0;
        ch0_a = 12'h0F0;
        ch1_a = 12'hABC;
        ch0_b = 12'h000;
        ch1_b = 12'h7FF;
        step(3);
        chk("rst_out", 32'(adc_out), 32'h0);
        chk("rst_busy", 32'(conv_busy), 32'h0);
        chk("rst_abort", 32'(abort_cnt), 32'h0);
        rst_n = 1'b1;
        step(2);

        cs_n = 1'b0;
        step(6);
        chk("idle_cs_fall_out", 32'(adc_out), 32'h0);
        chk("idle_cs_fall_busy", 32'(conv_busy), 32'h0);
        release_cs();

        convert(-1, 12'h0, busy_n);
        chk("conv_len", 32'(busy_n), 32'd150);
        chk("ready_out", 32'(adc_out), 32'h0);
        read(12, r0, r1);
        chk("a_ch0", 32'(r0), 32'h0F0);
        chk("a_ch1", 32'(r1), 32'hABC);
        chk("done_out", 32'(adc_out), 32'h0);
        release_cs();
        chk("no_abort", 32'(abort_cnt), 32'h0);

        sel = 1'b1;
        ub = 1'b1;
        convert(-1, 12'h0, busy_n);
        read(12, r0, r1);
        chk("b_ub_ch0", 32'(r0), 32'h800);
        chk("b_ub_ch1", 32'(r1), 32'hFFF);
        release_cs();

        sel = 1'b0;
        ub = 1'b0;
        ch0_a = 12'h5A5;
        ch1_a = 12'h3C3;
        convert(-1, 12'h0, busy_n);
        read(5, r0, r1);
        release_cs();
        chk("abort_cs_cnt", 32'(abort_cnt), 32'd1);
        chk("abort_cs_out", 32'(adc_out), 32'h0);
        convert(-1, 12'h0, busy_n);
        read(12, r0, r1);
        chk("after_abort_ch0", 32'(r0), 32'h5A5);
        chk("after_abort_ch1", 32'(r1), 32'h3C3);
        release_cs();
        chk("after_abort_cnt", 32'(abort_cnt), 32'd1);

        ch0_a = 12'h111;
        convert(20, 12'h222, busy_n);
        chk("ignored_cnvst_len", 32'(busy_n), 32'd150);
        read(12, r0, r1);
        chk("ignored_cnvst_latch", 32'(r0), 32'h111);
        release_cs();

        ch0_a = 12'h246;
        convert(-1, 12'h0, busy_n);
        read(3, r0, r1);
        ch0_a = 12'h9C8;
        cnvst = 1'b1;
        step(2);
        cnvst = 1'b0;
        step(2);
        chk("shift_cnvst_abort", 32'(abort_cnt), 32'd2);
        chk("shift_cnvst_busy", 32'(conv_busy), 32'h1);
        chk("shift_cnvst_out", 32'(adc_out), 32'h0);
        cs_n = 1'b1;
        for (int i = 0; i < 200 && conv_busy; i++) step(1);
        chk("restart_conv_end", 32'(conv_busy), 32'h0);
        read(12, r0, r1);
        chk("restart_latch", 32'(r0), 32'h9C8);
        release_cs();

        convert(-1, 12'h0, busy_n);
        read(4, r0, r1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out", 32'(adc_out), 32'h0);
        chk("rst_mid_busy", 32'(conv_busy), 32'h0);
        chk("rst_mid_abort", 32'(abort_cnt), 32'h0);
        step(2);
        rst_n = 1'b1;
        step(4);
        chk("post_rst_out", 32'(adc_out), 32'h0);
        release_cs();
        chk("post_rst_abort", 32'(abort_cnt), 32'h0);

        ch0_a = 12'hFFF;
        convert(-1, 12'h0, busy_n);
        read(12, r0, r1);
        chk("sat_ch0", 32'(r0), 32'hFFF);
        release_cs();
`ifndef ADC_RESPONDER_NOISE_EN
        ch0_a = 12'h123;
        convert(-1, 12'h0, busy_n);
        read(12, r0, r1);
        chk("exact_ch0", 32'(r0), 32'h123);
        release_cs();
`endif

        for (int k = 0; k < 255; k++) begin
            convert(-1, 12'h0, busy_n);
            read(0, r0, r1);
            release_cs();
        end
        chk("abort_255", 32'(abort_cnt), 32'd255);
        convert(-1, 12'h0, busy_n);
        read(0, r0, r1);
        release_cs();
        chk("abort_sat", 32'(abort_cnt), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
